// File: rtl/channel_capture_buffer_pkg.sv
// Shared capture constants: FSM encodings and default geometry taken from the VGA timing.
// Default depth is one sample per visible pixel column.
package channel_capture_buffer_pkg;

    localparam int VGA_HOR_RES        = 640;

    localparam int CAP_MAX_CHAN_COUNT = 10;
    localparam int CAP_DEPTH          = VGA_HOR_RES;
    localparam int CAP_PRE_TRIG       = 64;
    localparam int CAP_STATE_W        = 3;

    localparam logic [CAP_STATE_W-1:0] CAP_IDLE      = 3'd0;
    localparam logic [CAP_STATE_W-1:0] CAP_FILL      = 3'd1;
    localparam logic [CAP_STATE_W-1:0] CAP_WAIT_TRIG = 3'd2;
    localparam logic [CAP_STATE_W-1:0] CAP_POST      = 3'd3;
    localparam logic [CAP_STATE_W-1:0] CAP_DONE      = 3'd4;

    function automatic logic cap_is_done(input logic [CAP_STATE_W-1:0] st);
        return st == CAP_DONE;
    endfunction

endpackage

// File: rtl/channel_capture_buffer_if.sv
// Probe/trigger inputs and renderer read port of the capture buffer.
// Latency: n/a (wires only); backpressure: none, the renderer reads every pixel clock.
interface channel_capture_buffer_if
    import channel_capture_buffer_pkg::*;
#(
    parameter int MAX_CHAN_COUNT = CAP_MAX_CHAN_COUNT,
    parameter int DEPTH          = CAP_DEPTH
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_CHAN_COUNT);

    logic                      sample_en;
    logic [MAX_CHAN_COUNT-1:0] probe_in;
    logic                      arm;
    logic [MAX_CHAN_COUNT-1:0] trig_mask;
    logic [MAX_CHAN_COUNT-1:0] trig_value;
    logic [AW-1:0]             rd_col;
    logic [CW-1:0]             channel_number;
    logic                      is_channel;
    logic                      sample_bit;
    logic                      sample_valid;
    logic [CAP_STATE_W-1:0]    capture_state;
    logic                      capture_done;

    modport master (
        output sample_en, probe_in, arm, trig_mask, trig_value,
        output rd_col, channel_number, is_channel,
        input  sample_bit, sample_valid, capture_state, capture_done
    );

    modport slave (
        input  sample_en, probe_in, arm, trig_mask, trig_value,
        input  rd_col, channel_number, is_channel,
        output sample_bit, sample_valid, capture_state, capture_done
    );

endinterface

// File: rtl/channel_capture_buffer_capture_ram.sv
// Simple dual-port sample RAM, one write port and one registered read port, no reset.
// Latency: 1 clk read; backpressure: none.
module capture_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdat,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdat
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_dat_d;
    logic [WIDTH-1:0] rd_dat_q;

    always_comb begin
        rd_dat_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rdat = rd_dat_q;

endmodule

// File: rtl/channel_capture_buffer.sv
// Triggered circular capture of probe bits, frozen after the trigger, read back per pixel column/channel.
// Latency: 1 clk from rd_col/channel_number to sample_bit; backpressure: none, samples taken on sample_en.
module channel_capture_buffer
    import channel_capture_buffer_pkg::*;
#(
    parameter int MAX_CHAN_COUNT = CAP_MAX_CHAN_COUNT,
    parameter int DEPTH          = CAP_DEPTH,
    parameter int PRE_TRIG       = CAP_PRE_TRIG
) (
    input  logic clk,
    input  logic rst_n,
    channel_capture_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_CHAN_COUNT);

    localparam logic [AW-1:0] PRE_W    = AW'(PRE_TRIG);
    localparam logic [AW-1:0] LAST_W   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] POST_LEN = AW'(DEPTH - PRE_TRIG - 1);
    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PRE_X    = (AW+1)'(PRE_TRIG);

    logic [CAP_STATE_W-1:0] state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          pre_cnt_q, pre_cnt_d;
    logic [AW-1:0]          post_cnt_q, post_cnt_d;
    logic [AW-1:0]          trig_addr_q, trig_addr_d;

    logic [CW-1:0]          chan_q, chan_d;
    logic                   oob_q, oob_d;
    logic                   valid_q, valid_d;

    logic                      trig_match;
    logic                      ram_we;
    logic [AW-1:0]             wr_ptr_inc;
    logic [AW:0]               start_x;
    logic [AW:0]               sum_x;
    logic [AW-1:0]             rd_addr;
    logic [MAX_CHAN_COUNT-1:0] rd_dat;
    logic                      sample_bit;

    assign trig_match = ((bus.probe_in ^ bus.trig_value) & bus.trig_mask) == '0;

    // Depth need not be a power of two, so wrap by compare rather than masking.
    assign wr_ptr_inc = (wr_ptr_q == LAST_W) ? '0 : wr_ptr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        ram_we      = 1'b0;

        // A new arm always wins, including over a same-cycle trigger sample.
        if (bus.arm) begin
            state_d   = CAP_FILL;
            wr_ptr_d  = '0;
            pre_cnt_d = '0;
        end else begin
            case (state_q)
                CAP_FILL: begin
                    if (PRE_TRIG == 0) begin
                        state_d = CAP_WAIT_TRIG;
                    end else if (bus.sample_en) begin
                        ram_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_inc;
                        pre_cnt_d = pre_cnt_q + 1'b1;
                        if (pre_cnt_q + 1'b1 == PRE_W) begin
                            state_d = CAP_WAIT_TRIG;
                        end
                    end
                end
                CAP_WAIT_TRIG: begin
                    if (bus.sample_en) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_inc;
                        if (trig_match) begin
                            trig_addr_d = wr_ptr_q;
                            post_cnt_d  = POST_LEN;
                            state_d     = (POST_LEN == '0) ? CAP_DONE : CAP_POST;
                        end
                    end
                end
                CAP_POST: begin
                    if (bus.sample_en) begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_inc;
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) begin
                            state_d = CAP_DONE;
                        end
                    end
                end
                CAP_IDLE, CAP_DONE: begin
                end
                default: state_d = CAP_IDLE;
            endcase
        end
    end

    // Column 0 maps to PRE_TRIG samples before the trigger, modulo the ring depth.
    always_comb begin
        if (trig_addr_q >= PRE_W) begin
            start_x = {1'b0, trig_addr_q} - PRE_X;
        end else begin
            start_x = {1'b0, trig_addr_q} + DEPTH_X - PRE_X;
        end
        sum_x = start_x + {1'b0, bus.rd_col};
        oob_d = ({1'b0, bus.rd_col} >= DEPTH_X);
        if (oob_d) begin
            rd_addr = '0;
        end else if (sum_x >= DEPTH_X) begin
            rd_addr = AW'(sum_x - DEPTH_X);
        end else begin
            rd_addr = AW'(sum_x);
        end
        chan_d  = bus.channel_number;
        valid_d = cap_is_done(state_q) & bus.is_channel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CAP_IDLE;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            chan_q      <= '0;
            oob_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            chan_q      <= chan_d;
            oob_q       <= oob_d;
            valid_q     <= valid_d;
        end
    end

    capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (MAX_CHAN_COUNT),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdat  (bus.probe_in),
        .raddr (rd_addr),
        .rdat  (rd_dat)
    );

    always_comb begin
        sample_bit = 1'b0;
        if (valid_q && !oob_q && (32'(chan_q) < MAX_CHAN_COUNT)) begin
            sample_bit = rd_dat[chan_q];
        end
    end

    assign bus.sample_bit    = sample_bit;
    assign bus.sample_valid  = valid_q;
    assign bus.capture_state = state_q;
    assign bus.capture_done  = cap_is_done(state_q);

endmodule

// File: tb/tb_channel_capture_buffer.sv
// Directed bench: two capture buffers (DEPTH 16/PRE_TRIG 4 and DEPTH 12/PRE_TRIG 0).
module tb_channel_capture_buffer;

    localparam int NCH     = 10;
    localparam int DEPTH_A = 16;
    localparam int PRE_A   = 4;
    localparam int DEPTH_B = 12;
    localparam int PRE_B   = 0;

    typedef struct {
        int         col;
        int         ch;
        logic [1:0] exp;
    } rd_vec_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    channel_capture_buffer_if #(.MAX_CHAN_COUNT(NCH), .DEPTH(DEPTH_A)) ifa ();
    channel_capture_buffer_if #(.MAX_CHAN_COUNT(NCH), .DEPTH(DEPTH_B)) ifb ();

    channel_capture_buffer #(.MAX_CHAN_COUNT(NCH), .DEPTH(DEPTH_A), .PRE_TRIG(PRE_A)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_a_n),
        .bus   (ifa.slave)
    );

    channel_capture_buffer #(.MAX_CHAN_COUNT(NCH), .DEPTH(DEPTH_B), .PRE_TRIG(PRE_B)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (ifb.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [NCH-1:0] p);
        ifa.probe_in  = p;
        ifa.sample_en = 1'b1;
        tick();
        ifa.sample_en = 1'b0;
    endtask

    task automatic push_b(input logic [NCH-1:0] p);
        ifb.probe_in  = p;
        ifb.sample_en = 1'b1;
        tick();
        ifb.sample_en = 1'b0;
    endtask

    task automatic arm_a();
        ifa.arm = 1'b1;
        tick();
        ifa.arm = 1'b0;
    endtask

    task automatic arm_b();
        ifb.arm = 1'b1;
        tick();
        ifb.arm = 1'b0;
    endtask

    task automatic read_a(input int col, input int ch, input logic isc, output logic [1:0] vb);
        ifa.rd_col         = 4'(col);
        ifa.channel_number = 4'(ch);
        ifa.is_channel     = isc;
        tick();
        vb = {ifa.sample_valid, ifa.sample_bit};
    endtask

    task automatic read_b(input int col, input int ch, input logic isc, output logic [1:0] vb);
        ifb.rd_col         = 4'(col);
        ifb.channel_number = 4'(ch);
        ifb.is_channel     = isc;
        tick();
        vb = {ifb.sample_valid, ifb.sample_bit};
    endtask

    // Probe word for the wrap scenario: ch0 low for the first 40 samples, then high.
    function automatic logic [NCH-1:0] t2_val(input int k);
        logic [NCH-1:0] v;
        v = NCH'(k << 1);
        if (k >= 40) v[0] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        vec_cnt++;
        if ({ifa.capture_state, ifa.capture_done, ifa.sample_valid, ifa.sample_bit} !== 6'b0) begin
            err_cnt++;
            $display("FAIL reset_a: state/done/valid/bit=%b want 000000",
                     {ifa.capture_state, ifa.capture_done, ifa.sample_valid, ifa.sample_bit});
        end
        vec_cnt++;
        if ({ifb.capture_state, ifb.capture_done, ifb.sample_valid, ifb.sample_bit} !== 6'b0) begin
            err_cnt++;
            $display("FAIL reset_b: state/done/valid/bit=%b want 000000",
                     {ifb.capture_state, ifb.capture_done, ifb.sample_valid, ifb.sample_bit});
        end
    endtask

    task automatic test_basic_capture();
        logic [1:0] vb;
        logic [NCH-1:0] w;
        ifa.trig_mask  = '0;
        ifa.trig_value = '0;
        arm_a();
        vec_cnt++;
        if (ifa.capture_state !== 3'd1) begin
            err_cnt++;
            $display("FAIL t1_arm_state: got %0d want 1", ifa.capture_state);
        end
        for (int k = 0; k < 16; k++) begin
            push_a(NCH'(k + 1));
            if (k == 3 || k == 4 || k == 14 || k == 15) begin
                logic [2:0] exp_st;
                exp_st = (k == 3) ? 3'd2 : (k == 15) ? 3'd4 : 3'd3;
                vec_cnt++;
                if (ifa.capture_state !== exp_st) begin
                    err_cnt++;
                    $display("FAIL t1_state_after_%0d: got %0d want %0d", k + 1, ifa.capture_state, exp_st);
                end
            end
        end
        vec_cnt++;
        if (ifa.capture_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL t1_done: got %b want 1", ifa.capture_done);
        end
        push_a(10'h3FF);
        vec_cnt++;
        if (ifa.capture_state !== 3'd4) begin
            err_cnt++;
            $display("FAIL t1_frozen_state: got %0d want 4", ifa.capture_state);
        end
        for (int c = 0; c <= 4; c++) begin
            for (int ch = 0; ch < 4; ch++) begin
                read_a(c, ch, 1'b1, vb);
                w = NCH'(c + 1);
                vec_cnt++;
                if (vb !== {1'b1, w[ch]}) begin
                    err_cnt++;
                    $display("FAIL t1_read_c%0d_ch%0d: valid/bit=%b want %b", c, ch, vb, {1'b1, w[ch]});
                end
            end
        end
    endtask

    task automatic test_wrap_trigger();
        logic [1:0] vb;
        logic [NCH-1:0] w;
        ifa.trig_mask  = 10'h001;
        ifa.trig_value = 10'h001;
        arm_a();
        for (int k = 0; k < 52; k++) begin
            push_a(t2_val(k));
            if (k == 39 || k == 40 || k == 50 || k == 51) begin
                logic [2:0] exp_st;
                exp_st = (k == 39) ? 3'd2 : (k == 51) ? 3'd4 : 3'd3;
                vec_cnt++;
                if (ifa.capture_state !== exp_st) begin
                    err_cnt++;
                    $display("FAIL t2_state_after_%0d: got %0d want %0d", k + 1, ifa.capture_state, exp_st);
                end
            end
        end
        for (int c = 0; c < DEPTH_A; c++) begin
            read_a(c, 0, 1'b1, vb);
            w = t2_val(36 + c);
            vec_cnt++;
            if (vb !== {1'b1, w[0]}) begin
                err_cnt++;
                $display("FAIL t2_ch0_col%0d: valid/bit=%b want %b", c, vb, {1'b1, w[0]});
            end
        end
        for (int c = 3; c <= 4; c++) begin
            w = t2_val(36 + c);
            for (int ch = 0; ch < NCH; ch++) begin
                read_a(c, ch, 1'b1, vb);
                vec_cnt++;
                if (vb !== {1'b1, w[ch]}) begin
                    err_cnt++;
                    $display("FAIL t2_col%0d_ch%0d: valid/bit=%b want %b", c, ch, vb, {1'b1, w[ch]});
                end
            end
        end
    endtask

    task automatic test_read_latency();
        logic [1:0] vb;
        read_a(3, 2, 1'b1, vb);
        vec_cnt++;
        if (vb !== 2'b11) begin
            err_cnt++;
            $display("FAIL t3_col3_ch2: valid/bit=%b want 11", vb);
        end
        ifa.rd_col         = 4'd5;
        ifa.channel_number = 4'd2;
        #2;
        vec_cnt++;
        if ({ifa.sample_valid, ifa.sample_bit} !== 2'b11) begin
            err_cnt++;
            $display("FAIL t3_hold_before_edge: valid/bit=%b want 11",
                     {ifa.sample_valid, ifa.sample_bit});
        end
        tick();
        vec_cnt++;
        if ({ifa.sample_valid, ifa.sample_bit} !== 2'b10) begin
            err_cnt++;
            $display("FAIL t3_col5_ch2: valid/bit=%b want 10", {ifa.sample_valid, ifa.sample_bit});
        end
        read_a(3, 2, 1'b0, vb);
        vec_cnt++;
        if (vb !== 2'b00) begin
            err_cnt++;
            $display("FAIL t3_not_channel: valid/bit=%b want 00", vb);
        end
    endtask

    task automatic test_arm_restart();
        logic [1:0] vb;
        ifa.trig_mask = '0;
        arm_a();
        for (int k = 0; k < 5; k++) push_a(NCH'(k));
        vec_cnt++;
        if (ifa.capture_state !== 3'd3) begin
            err_cnt++;
            $display("FAIL t4_in_post: got %0d want 3", ifa.capture_state);
        end
        arm_a();
        vec_cnt++;
        if (ifa.capture_state !== 3'd1) begin
            err_cnt++;
            $display("FAIL t4_rearm_state: got %0d want 1", ifa.capture_state);
        end
        read_a(0, 0, 1'b1, vb);
        vec_cnt++;
        if (vb !== 2'b00) begin
            err_cnt++;
            $display("FAIL t4_valid_not_done: valid/bit=%b want 00", vb);
        end
        for (int k = 0; k < 3; k++) push_a(NCH'(k));
        vec_cnt++;
        if (ifa.capture_state !== 3'd1) begin
            err_cnt++;
            $display("FAIL t4_precnt_restart: got %0d want 1", ifa.capture_state);
        end
        push_a(10'h003);
        vec_cnt++;
        if (ifa.capture_state !== 3'd2) begin
            err_cnt++;
            $display("FAIL t4_wait_after_4: got %0d want 2", ifa.capture_state);
        end
        ifa.arm       = 1'b1;
        ifa.sample_en = 1'b1;
        ifa.probe_in  = 10'h155;
        tick();
        ifa.arm       = 1'b0;
        ifa.sample_en = 1'b0;
        vec_cnt++;
        if (ifa.capture_state !== 3'd1) begin
            err_cnt++;
            $display("FAIL t4_arm_beats_trigger: got %0d want 1", ifa.capture_state);
        end
        for (int k = 0; k < 7; k++) push_a(NCH'(k));
        vec_cnt++;
        if (ifa.capture_state !== 3'd3) begin
            err_cnt++;
            $display("FAIL t4_post_again: got %0d want 3", ifa.capture_state);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        rst_a_n = 1'b0;
        #1;
        vec_cnt++;
        if ({ifa.capture_state, ifa.capture_done, ifa.sample_valid, ifa.sample_bit} !== 6'b0) begin
            err_cnt++;
            $display("FAIL t5_async_clear: state/done/valid/bit=%b want 000000",
                     {ifa.capture_state, ifa.capture_done, ifa.sample_valid, ifa.sample_bit});
        end
        #2;
        rst_a_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) push_a(NCH'(k));
        vec_cnt++;
        if (ifa.capture_state !== 3'd0) begin
            err_cnt++;
            $display("FAIL t5_idle_ignores_samples: got %0d want 0", ifa.capture_state);
        end
        arm_a();
        vec_cnt++;
        if (ifa.capture_state !== 3'd1) begin
            err_cnt++;
            $display("FAIL t5_arm_after_reset: got %0d want 1", ifa.capture_state);
        end
    endtask

    task automatic test_pre_trig_zero();
        logic [1:0] vb;
        rd_vec_t tab [15];
        ifb.trig_mask  = 10'h003;
        ifb.trig_value = 10'h002;
        arm_b();
        vec_cnt++;
        if (ifb.capture_state !== 3'd1) begin
            err_cnt++;
            $display("FAIL t6_fill: got %0d want 1", ifb.capture_state);
        end
        tick();
        vec_cnt++;
        if (ifb.capture_state !== 3'd2) begin
            err_cnt++;
            $display("FAIL t6_fill_one_cycle: got %0d want 2", ifb.capture_state);
        end
        push_b(10'h101);
        push_b(10'h100);
        vec_cnt++;
        if (ifb.capture_state !== 3'd2) begin
            err_cnt++;
            $display("FAIL t6_no_match: got %0d want 2", ifb.capture_state);
        end
        push_b(10'h2FE);
        vec_cnt++;
        if (ifb.capture_state !== 3'd3) begin
            err_cnt++;
            $display("FAIL t6_trigger: got %0d want 3", ifb.capture_state);
        end
        for (int k = 3; k <= 13; k++) begin
            push_b(NCH'(10'h040 + k));
            if (k >= 12) begin
                logic [2:0] exp_st;
                exp_st = (k == 13) ? 3'd4 : 3'd3;
                vec_cnt++;
                if (ifb.capture_state !== exp_st) begin
                    err_cnt++;
                    $display("FAIL t6_state_after_%0d: got %0d want %0d", k + 1, ifb.capture_state, exp_st);
                end
            end
        end
        tab = '{'{0, 9, 2'b11}, '{0, 1, 2'b11}, '{0, 0, 2'b10}, '{0, 10, 2'b10}, '{0, 15, 2'b10},
                '{12, 1, 2'b10}, '{15, 1, 2'b10}, '{11, 0, 2'b11}, '{11, 2, 2'b11}, '{11, 1, 2'b10},
                '{10, 0, 2'b10}, '{10, 2, 2'b11}, '{1, 0, 2'b11}, '{1, 1, 2'b11}, '{1, 2, 2'b10}};
        for (int i = 0; i < 15; i++) begin
            read_b(tab[i].col, tab[i].ch, 1'b1, vb);
            vec_cnt++;
            if (vb !== tab[i].exp) begin
                err_cnt++;
                $display("FAIL t6_col%0d_ch%0d: valid/bit=%b want %b", tab[i].col, tab[i].ch, vb, tab[i].exp);
            end
        end
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ifa.sample_en = 1'b0; ifa.probe_in = '0; ifa.arm = 1'b0;
        ifa.trig_mask = '0; ifa.trig_value = '0;
        ifa.rd_col = '0; ifa.channel_number = '0; ifa.is_channel = 1'b0;
        ifb.sample_en = 1'b0; ifb.probe_in = '0; ifb.arm = 1'b0;
        ifb.trig_mask = '0; ifb.trig_value = '0;
        ifb.rd_col = '0; ifb.channel_number = '0; ifb.is_channel = 1'b0;
        tick();
        tick();
        test_reset();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick();
        test_basic_capture();
        test_wrap_trigger();
        test_read_latency();
        test_arm_restart();
        test_async_reset();
        test_pre_trig_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
